// File: rtl/instruction_fetch_pkg.sv
// Shared widths, fetch FSM encodings and queue entry layout for the fetch unit.
package instruction_fetch_pkg;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int DATA_WIDTH        = 32;
  localparam int FETCH_STATE_WIDTH = 2;

  typedef enum logic [FETCH_STATE_WIDTH-1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]        pc;
    logic [INSTRUCTION_WIDTH-1:0] inst;
  } fetch_entry_t;

  function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] addr);
    return {addr[DATA_WIDTH-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/instruction_fetch_queue.sv
// In-order {pc, instruction} FIFO; head is read straight from storage, flush beats push.
module instruction_queue
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [DATA_WIDTH-1:0]        push_pc,
  input  logic [INSTRUCTION_WIDTH-1:0] push_inst,
  output logic [CW-1:0]                count,
  output logic [DATA_WIDTH-1:0]        head_pc,
  output logic [INSTRUCTION_WIDTH-1:0] head_inst
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  // Storage is cleared on reset so the head reads zero before the first push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: push_pc, inst: push_inst};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_pc   = mem[rd_ptr].pc;
  assign head_inst = mem[rd_ptr].inst;
endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetcher with prefetch queue and redirect/flush handling.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    DEPTH    = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         memReq,
  output logic [DATA_WIDTH-1:0]        memAddr,
  input  logic                         memGnt,
  input  logic                         memRespValid,
  input  logic [INSTRUCTION_WIDTH-1:0] memData,
  output logic                         instValid,
  input  logic                         instReady,
  output logic [INSTRUCTION_WIDTH-1:0] instructionOut,
  output logic [DATA_WIDTH-1:0]        pcOut,
  input  logic                         redirect,
  input  logic [DATA_WIDTH-1:0]        redirectTarget,
  output logic                         fetchError
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state;
  logic [CW-1:0] count, count_next;
  logic          grant, push, pop, space, to_fetch;

  assign grant      = memReq && memGnt;
  assign push       = (state == WAIT) && memRespValid && !redirect;
  assign pop        = instValid && instReady;
  assign count_next = redirect ? '0 : count + CW'(push) - CW'(pop);
  // Only consulted when entering/staying in FETCH, where nothing is outstanding.
  assign space      = count_next < CW'(DEPTH);
  assign instValid  = (count != '0);
  // On redirect: resume fetching only if no response is still owed to us.
  assign to_fetch   = (state == FETCH) ? !grant : memRespValid;

  instruction_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (redirect),
    .push_pc  (memAddr - DATA_WIDTH'(4)),
    .push_inst(memData),
    .count    (count),
    .head_pc  (pcOut),
    .head_inst(instructionOut)
  );

  // memAddr is the fetch PC; it advances on grant so WAIT pushes memAddr-4.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      memReq     <= 1'b0;
      memAddr    <= RESET_PC;
      fetchError <= 1'b0;
    end else begin
      fetchError <= redirect && (redirectTarget[1:0] != 2'b00);
      memReq     <= 1'b0;
      if (redirect) begin
        memAddr <= word_align(redirectTarget);
        if (to_fetch) begin
          state  <= FETCH;
          memReq <= space;
        end else begin
          state <= DISCARD;
        end
      end else begin
        case (state)
          FETCH: begin
            if (grant) begin
              state   <= WAIT;
              memAddr <= memAddr + DATA_WIDTH'(4);
            end else begin
              memReq <= space;
            end
          end
          WAIT, DISCARD: begin
            if (memRespValid) begin
              state  <= FETCH;
              memReq <= space;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, backpressure, redirects, PC wrap, async reset.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt;
  logic        memRespValid = 1'b0;
  logic [31:0] memData = 32'h0;
  logic        instValid;
  logic        instReady = 1'b1;
  logic [31:0] instructionOut;
  logic [31:0] pcOut;
  logic        redirect = 1'b0;
  logic [31:0] redirectTarget = 32'h0;
  logic        fetchError;

  int checks = 0;
  int failures = 0;

  logic        auto_mem = 1'b1;
  logic        gnt_en = 1'b1;
  logic        rsp_g;
  logic [31:0] rsp_a;
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];

  always #5 clk = ~clk;
  assign memGnt = gnt_en;

  instruction_fetch #(.DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .memReq(memReq), .memAddr(memAddr), .memGnt(memGnt),
    .memRespValid(memRespValid), .memData(memData), .instValid(instValid),
    .instReady(instReady), .instructionOut(instructionOut), .pcOut(pcOut),
    .redirect(redirect), .redirectTarget(redirectTarget), .fetchError(fetchError)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Single-cycle memory: a grant at one edge yields data during the next cycle.
  always @(posedge clk) begin
    if (auto_mem) begin
      rsp_g = memReq && memGnt;
      rsp_a = memAddr;
      #1;
      memRespValid = rsp_g;
      memData      = word_of(rsp_a);
    end
  end

  always @(posedge clk) begin
    if (!reset && instValid && instReady) begin
      got_pc.push_back(pcOut);
      got_inst.push_back(instructionOut);
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic clear_got();
    got_pc.delete();
    got_inst.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    @(negedge clk); @(negedge clk);
    clear_got();
    reset = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k = 0;
    while (got_pc.size() < n && k < 60) begin cyc(); k++; end
    if (got_pc.size() < n) begin
      checks++; failures++;
      $display("FAIL wait_got: have %0d entries, need %0d", got_pc.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL reset_memReq: got %b want 0", memReq); end
    checks++; if (memAddr !== 32'h0) begin failures++; $display("FAIL reset_memAddr: got %h want 0", memAddr); end
    checks++; if (instValid !== 1'b0) begin failures++; $display("FAIL reset_instValid: got %b want 0", instValid); end
    checks++; if (instructionOut !== 32'h0) begin failures++; $display("FAIL reset_instructionOut: got %h want 0", instructionOut); end
    checks++; if (pcOut !== 32'h0) begin failures++; $display("FAIL reset_pcOut: got %h want 0", pcOut); end
    checks++; if (fetchError !== 1'b0) begin failures++; $display("FAIL reset_fetchError: got %b want 0", fetchError); end
  endtask

  task automatic test_stream();
    int n;
    instReady = 1'b1; gnt_en = 1'b1; auto_mem = 1'b1;
    do_reset();
    cyc(); n = 1;
    checks++; if (memReq !== 1'b1) begin failures++; $display("FAIL first_memReq: got %b want 1", memReq); end
    while (!instValid && n < 10) begin cyc(); n++; end
    checks++; if (n !== 3) begin failures++; $display("FAIL first_instValid_latency: got %0d want 3", n); end
    wait_got(4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_pc[i] !== 32'(4*i)) begin failures++; $display("FAIL stream_pc[%0d]: got %h want %h", i, got_pc[i], 32'(4*i)); end
      checks++; if (got_inst[i] !== word_of(32'(4*i))) begin failures++; $display("FAIL stream_inst[%0d]: got %h want %h", i, got_inst[i], word_of(32'(4*i))); end
    end
  endtask

  task automatic test_backpressure();
    instReady = 1'b0;
    do_reset();
    repeat (10) cyc();
    checks++; if (instValid !== 1'b1) begin failures++; $display("FAIL bp_instValid: got %b want 1", instValid); end
    checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL bp_memReq_full: got %b want 0", memReq); end
    checks++; if (pcOut !== 32'h0) begin failures++; $display("FAIL bp_head_pc: got %h want 0", pcOut); end
    checks++; if (got_pc.size() !== 0) begin failures++; $display("FAIL bp_no_pop: got %0d pops want 0", got_pc.size()); end
    instReady = 1'b1;
    wait_got(4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_pc[i] !== 32'(4*i)) begin failures++; $display("FAIL bp_drain_pc[%0d]: got %h want %h", i, got_pc[i], 32'(4*i)); end
    end
  endtask

  task automatic test_redirect_inflight();
    bit saw8 = 1'b0;
    instReady = 1'b1; gnt_en = 1'b1;
    auto_mem = 1'b0; memRespValid = 1'b0;
    do_reset();
    cyc();                                   // request for 0 visible
    cyc();                                   // granted
    memRespValid = 1'b1; memData = word_of(32'h0);
    cyc();
    memRespValid = 1'b0;
    cyc();                                   // 4 granted
    memRespValid = 1'b1; memData = word_of(32'h4);
    cyc();
    memRespValid = 1'b0;
    checks++; if (memReq !== 1'b1 || memAddr !== 32'h8) begin failures++; $display("FAIL inflight_req8: got req=%b addr=%h want 1/8", memReq, memAddr); end
    cyc();                                   // 8 granted, now in flight
    redirect = 1'b1; redirectTarget = 32'h100;
    cyc();
    redirect = 1'b0;
    checks++; if (instValid !== 1'b0 || memReq !== 1'b0) begin failures++; $display("FAIL inflight_discard: got valid=%b req=%b want 0/0", instValid, memReq); end
    memRespValid = 1'b1; memData = word_of(32'h8);
    cyc();                                   // late response for 8 is dropped
    memRespValid = 1'b0;
    checks++; if (memReq !== 1'b1 || memAddr !== 32'h100) begin failures++; $display("FAIL inflight_refetch: got req=%b addr=%h want 1/100", memReq, memAddr); end
    auto_mem = 1'b1;
    wait_got(3);
    checks++; if (got_pc[2] !== 32'h100) begin failures++; $display("FAIL inflight_next_pc: got %h want 100", got_pc[2]); end
    checks++; if (got_inst[2] !== word_of(32'h100)) begin failures++; $display("FAIL inflight_next_inst: got %h want %h", got_inst[2], word_of(32'h100)); end
    foreach (got_pc[i]) if (got_pc[i] === 32'h8) saw8 = 1'b1;
    checks++; if (saw8 !== 1'b0) begin failures++; $display("FAIL inflight_dropped8: got pc 8 delivered want never"); end
  endtask

  task automatic test_misaligned();
    redirect = 1'b1; redirectTarget = 32'h102;
    cyc();
    redirect = 1'b0;
    clear_got();
    checks++; if (fetchError !== 1'b1) begin failures++; $display("FAIL misalign_pulse: got %b want 1", fetchError); end
    cyc();
    checks++; if (fetchError !== 1'b0) begin failures++; $display("FAIL misalign_one_cycle: got %b want 0", fetchError); end
    wait_got(1);
    checks++; if (got_pc[0] !== 32'h100) begin failures++; $display("FAIL misalign_pc: got %h want 100", got_pc[0]); end
    checks++; if (got_inst[0] !== word_of(32'h100)) begin failures++; $display("FAIL misalign_inst: got %h want %h", got_inst[0], word_of(32'h100)); end
  endtask

  task automatic test_resp_same_cycle();
    int k = 0;
    while (memRespValid !== 1'b1 && k < 20) begin cyc(); k++; end
    checks++; if (memRespValid !== 1'b1) begin failures++; $display("FAIL resp_wait: got no response within 20 cycles"); end
    redirect = 1'b1; redirectTarget = 32'h200;
    cyc();
    redirect = 1'b0;
    clear_got();
    checks++; if (instValid !== 1'b0) begin failures++; $display("FAIL resp_redirect_not_enqueued: got valid=%b want 0", instValid); end
    checks++; if (memReq !== 1'b1 || memAddr !== 32'h200) begin failures++; $display("FAIL resp_redirect_req: got req=%b addr=%h want 1/200", memReq, memAddr); end
    wait_got(1);
    checks++; if (got_pc[0] !== 32'h200) begin failures++; $display("FAIL resp_redirect_pc: got %h want 200", got_pc[0]); end
  endtask

  task automatic test_gnt_same_cycle();
    int k = 0;
    while (memReq !== 1'b1 && k < 20) begin cyc(); k++; end
    redirect = 1'b1; redirectTarget = 32'h300;
    cyc();
    redirect = 1'b0;
    clear_got();
    checks++; if (memReq !== 1'b0 || memAddr !== 32'h300) begin failures++; $display("FAIL gnt_redirect_discard: got req=%b addr=%h want 0/300", memReq, memAddr); end
    wait_got(1);
    checks++; if (got_pc[0] !== 32'h300) begin failures++; $display("FAIL gnt_redirect_pc: got %h want 300", got_pc[0]); end
    checks++; if (got_inst[0] !== word_of(32'h300)) begin failures++; $display("FAIL gnt_redirect_inst: got %h want %h", got_inst[0], word_of(32'h300)); end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
    redirect = 1'b1; redirectTarget = 32'hFFFF_FFF8;
    cyc();
    redirect = 1'b0;
    clear_got();
    checks++; if (fetchError !== 1'b0) begin failures++; $display("FAIL wrap_no_error: got %b want 0", fetchError); end
    wait_got(3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, got_pc[i], exp_pc[i]); end
    end
  endtask

  task automatic test_reset_mid_wait();
    instReady = 1'b0;
    do_reset();
    repeat (4) cyc();                        // one word queued, second request granted
    checks++; if (instValid !== 1'b1 || memReq !== 1'b0) begin failures++; $display("FAIL midwait_setup: got valid=%b req=%b want 1/0", instValid, memReq); end
    #1 reset = 1'b1;
    #1;
    checks++; if (instValid !== 1'b0 || memReq !== 1'b0 || memAddr !== 32'h0) begin failures++; $display("FAIL midwait_async_clear: got valid=%b req=%b addr=%h want 0/0/0", instValid, memReq, memAddr); end
    #2 reset = 1'b0;
    cyc();                                   // stale response lands while in FETCH
    checks++; if (instValid !== 1'b0) begin failures++; $display("FAIL midwait_stale_ignored: got valid=%b want 0", instValid); end
    checks++; if (memReq !== 1'b1 || memAddr !== 32'h0) begin failures++; $display("FAIL midwait_restart: got req=%b addr=%h want 1/0", memReq, memAddr); end
    instReady = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_misaligned();
    test_resp_same_cycle();
    test_gnt_same_cycle();
    test_pc_wrap();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
